// File: rtl/lfsr_datapath_if.sv
// Control/status bundle between the LFSR sequencing FSM and lfsr_datapath.
//   master : FSM side. It drives the control word (raddr1, raddr2, wen, waddr, wdsrc, func,
//            constant) and observes is_zero, alu_out, result_q, zflag_q and lfsr_out.
//   slave  : datapath side. The directions are the mirror image of master.
interface lfsr_datapath_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 4
) ();
  logic [AW-1:0]     raddr1;
  logic [AW-1:0]     raddr2;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic              wdsrc;
  logic [3:0]        func;
  logic [DATA_W-1:0] constant;
  logic              is_zero;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] result_q;
  logic              zflag_q;
  logic [DATA_W-1:0] lfsr_out;

  modport master (
    output raddr1, raddr2, wen, waddr, wdsrc, func, constant,
    input  is_zero, alu_out, result_q, zflag_q, lfsr_out
  );

  modport slave (
    input  raddr1, raddr2, wen, waddr, wdsrc, func, constant,
    output is_zero, alu_out, result_q, zflag_q, lfsr_out
  );
endinterface

// File: rtl/lfsr_datapath.sv
// Register file and ALU datapath for the LFSR sequencing FSM.
// Each cycle the datapath executes one ALU operation from the control word on `bus`. When wen
// is set, it writes the result back to rf[waddr]. It also latches the result and the zero flag
// into result_q and zflag_q.
// Ports:
//   clk, rst : clock; synchronous active-high reset that clears the register file and flags
//   bus      : lfsr_datapath_if.slave carrying the control word and the status outputs
//              (is_zero, alu_out, result_q, zflag_q, lfsr_out = rf[LFSR_REG])
// Optional debug, enabled by the macro LFSR_DP_DBG_EN:
//   dbg_raddr : asynchronous debug read address
//   dbg_rdata : rf[dbg_raddr]
//   wr_count  : 16-bit count of wen cycles; it wraps and is cleared by rst
module lfsr_datapath #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREG     = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned LFSR_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LFSR_DP_DBG_EN
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [15:0]       wr_count,
`endif
  lfsr_datapath_if.slave    bus
);

  localparam logic [3:0] OpPassB = 4'd0;
  localparam logic [3:0] OpAdd   = 4'd1;
  localparam logic [3:0] OpSub   = 4'd2;
  localparam logic [3:0] OpAnd   = 4'd3;
  localparam logic [3:0] OpOr    = 4'd4;
  localparam logic [3:0] OpXor   = 4'd5;
  localparam logic [3:0] OpShl   = 4'd6;
  localparam logic [3:0] OpShr   = 4'd7;
  localparam logic [3:0] OpSra   = 4'd8;
  localparam logic [3:0] OpSlt   = 4'd9;
  localparam logic [3:0] OpSltu  = 4'd10;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [DATA_W-1:0] result_q, result_d;
  logic              zflag_q, zflag_d;
  logic [DATA_W-1:0] op_a, op_b, alu;
  logic [4:0]        shamt;

  // Reads are asynchronous from the flops, so a write in this cycle is not forwarded.
  assign op_a  = rf_q[bus.raddr1];
  assign op_b  = bus.wdsrc ? rf_q[bus.raddr2] : bus.constant;
  assign shamt = op_b[4:0];

  always_comb begin
    alu = '0;
    case (bus.func)
      OpPassB: alu = op_b;
      OpAdd:   alu = op_a + op_b;
      OpSub:   alu = op_a - op_b;
      OpAnd:   alu = op_a & op_b;
      OpOr:    alu = op_a | op_b;
      OpXor:   alu = op_a ^ op_b;
      OpShl:   alu = op_a << shamt;
      OpShr:   alu = op_a >> shamt;
      OpSra:   alu = $unsigned($signed(op_a) >>> shamt);
      OpSlt:   alu = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OpSltu:  alu = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      default: alu = '0;
    endcase
  end

  assign bus.alu_out  = alu;
  assign bus.is_zero  = (alu == '0);
  assign bus.result_q = result_q;
  assign bus.zflag_q  = zflag_q;
  assign bus.lfsr_out = rf_q[LFSR_REG];

  // Writes are decoded per entry. An out-of-range waddr therefore writes nothing, and with
  // wen=0 no entry can change whatever the other controls hold.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (bus.wen && (bus.waddr == AW'(i))) begin
        rf_d[i] = alu;
      end
    end
    result_d = result_q;
    zflag_d  = zflag_q;
    if (bus.wen) begin
      result_d = alu;
      zflag_d  = bus.is_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      result_q <= '0;
      zflag_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
      result_q <= result_d;
      zflag_q  <= zflag_d;
    end
  end

`ifdef LFSR_DP_DBG_EN
  logic [15:0] wr_count_q, wr_count_d;

  assign dbg_rdata = rf_q[dbg_raddr];
  assign wr_count  = wr_count_q;

  always_comb begin
    wr_count_d = wr_count_q;
    if (bus.wen) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_datapath.sv
// Scoreboard bench for lfsr_datapath. The stimulus process drives one control word per cycle
// and queues the expected observations, each tagged with the cycle in which it is due. The
// monitor samples the DUT on every falling edge and retires the entries that are due.
module tb_lfsr_datapath;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AW     = 4;

  localparam int SelAlu = 0, SelZero = 1, SelRes = 2, SelZflag = 3, SelLfsr = 4, SelWrCnt = 5;

  localparam logic [3:0] PASSB = 4'd0, ADD = 4'd1, SUB = 4'd2, XOR = 4'd5, SHL = 4'd6,
                         SHR = 4'd7, SRA = 4'd8, SLT = 4'd9, SLTU = 4'd10;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  chk_t sb[$];

  lfsr_datapath_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

`ifdef LFSR_DP_DBG_EN
  logic [AW-1:0]     dbg_raddr = '0;
  logic [DATA_W-1:0] dbg_rdata;
  logic [15:0]       wr_count;
`endif

  lfsr_datapath #(.DATA_W(DATA_W), .NREG(16), .AW(AW), .LFSR_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef LFSR_DP_DBG_EN
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .wr_count  (wr_count),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SelAlu:   return bus.alu_out;
      SelZero:  return {31'd0, bus.is_zero};
      SelRes:   return bus.result_q;
      SelZflag: return {31'd0, bus.zflag_q};
      SelLfsr:  return bus.lfsr_out;
`ifdef LFSR_DP_DBG_EN
      SelWrCnt: return {16'd0, wr_count};
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: retires every queued expectation that is due in the current cycle.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        act = sample(sb[i].sel);
        n_checks++;
        if (sb[i].cyc == cyc && act === sb[i].exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", sb[i].name, act,
                   sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(input int dly, input int sel, input logic [31:0] exp,
                           input string name);
    chk_t c;
    c.cyc = cyc + dly; c.sel = sel; c.exp = exp; c.name = name;
    sb.push_back(c);
  endtask

  task automatic check_now(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Applies one control word just after the rising edge. It stays valid for the whole cycle.
  task automatic step(input logic w, input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] wa, input logic src, input logic [3:0] fn,
                      input logic [31:0] k);
    @(posedge clk);
    #1;
    bus.wen = w; bus.raddr1 = ra1; bus.raddr2 = ra2; bus.waddr = wa;
    bus.wdsrc = src; bus.func = fn; bus.constant = k;
  endtask

  // Reads rf[r] through the ALU (PASSB of operand B) without writing anything.
  task automatic probe(input logic [3:0] r, input logic [31:0] exp, input string name);
    step(1'b0, 4'd0, r, 4'd0, 1'b1, PASSB, 32'd0);
    expect_at(0, SelAlu, exp, name);
  endtask

  initial begin
    bus.wen = 1'b0; bus.raddr1 = '0; bus.raddr2 = '0; bus.waddr = '0;
    bus.wdsrc = 1'b0; bus.func = PASSB; bus.constant = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    expect_at(0, SelLfsr, 32'd0, "reset_lfsr");
    expect_at(0, SelRes, 32'd0, "reset_result_q");
    expect_at(0, SelZflag, 32'd0, "reset_zflag_q");
    expect_at(0, SelZero, 32'd1, "reset_is_zero_passb0");

    // Seed r1 = 0xACE1.
    step(1'b1, 4'd0, 4'd0, 4'd1, 1'b0, PASSB, 32'h0000_ACE1);
    expect_at(0, SelAlu, 32'h0000_ACE1, "seed_alu");
    expect_at(1, SelLfsr, 32'h0000_ACE1, "seed_lfsr_out");
    expect_at(1, SelRes, 32'h0000_ACE1, "seed_result_q");
    expect_at(1, SelZflag, 32'd0, "seed_zflag_q");

    // r5 = r1 >> 2, then r6 = r1 ^ r5.
    step(1'b1, 4'd1, 4'd0, 4'd5, 1'b0, SHR, 32'd2);
    #1 check_now(bus.lfsr_out, 32'h0000_ACE1, "seed_lfsr_direct");
    expect_at(0, SelAlu, 32'h0000_2B38, "shr_alu");
    expect_at(0, SelZero, 32'd0, "shr_is_zero");
    step(1'b1, 4'd1, 4'd5, 4'd6, 1'b1, XOR, 32'd0);
    expect_at(0, SelAlu, 32'h0000_87D9, "xor_alu");
    expect_at(1, SelRes, 32'h0000_87D9, "xor_result_q");
    probe(4'd5, 32'h0000_2B38, "probe_r5");

    // ADD wrap on r3.
    step(1'b1, 4'd0, 4'd0, 4'd3, 1'b0, PASSB, 32'hFFFF_FFFF);
    step(1'b1, 4'd3, 4'd0, 4'd3, 1'b0, ADD, 32'd1);
    #1 check_now({31'd0, bus.is_zero}, 32'd1, "add_wrap_is_zero_direct");
    expect_at(0, SelAlu, 32'd0, "add_wrap_alu");
    expect_at(0, SelZero, 32'd1, "add_wrap_is_zero");
    expect_at(1, SelRes, 32'd0, "add_wrap_result_q");
    expect_at(1, SelZflag, 32'd1, "add_wrap_zflag_q");
    step(1'b1, 4'd3, 4'd0, 4'd3, 1'b0, ADD, 32'd1);
    expect_at(0, SelAlu, 32'd1, "add_again_alu");
    expect_at(0, SelZero, 32'd0, "add_again_is_zero");
    expect_at(1, SelZflag, 32'd0, "add_again_zflag_q");

    // Compare, shift and unused opcodes on r4 = 0xFFFFFFF0.
    step(1'b1, 4'd0, 4'd0, 4'd4, 1'b0, PASSB, 32'hFFFF_FFF0);
    step(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, SLT, 32'd15);
    #1 check_now(bus.alu_out, 32'd1, "slt_direct");
    expect_at(0, SelAlu, 32'd1, "slt");
    step(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, SLTU, 32'd15);
    expect_at(0, SelAlu, 32'd0, "sltu");
    step(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, 4'd13, 32'h1234_5678);
    expect_at(0, SelAlu, 32'd0, "op13_alu");
    expect_at(0, SelZero, 32'd1, "op13_is_zero");
    step(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, SRA, 32'd4);
    expect_at(0, SelAlu, 32'hFFFF_FFFF, "sra");
    step(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, SHL, 32'h0000_0021);
    expect_at(0, SelAlu, 32'hFFFF_FFE0, "shl_upper_bits_ignored");
    step(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, SHR, 32'h0000_0020);
    expect_at(0, SelAlu, 32'hFFFF_FFF0, "shr_by_zero");
    step(1'b0, 4'd4, 4'd0, 4'd0, 1'b0, SUB, 32'd15);
    expect_at(0, SelAlu, 32'hFFFF_FFE1, "sub");

    // wen=0 for five cycles must leave all state alone.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'(i), 4'(i + 7), 4'(i * 3), i[0], XOR, 32'hA5A5_0000 + 32'(i));
    end
    expect_at(0, SelRes, 32'hFFFF_FFF0, "hold_result_q");
    expect_at(0, SelZflag, 32'd0, "hold_zflag_q");
    expect_at(0, SelLfsr, 32'h0000_ACE1, "hold_lfsr");
    probe(4'd3, 32'd1, "hold_r3");

    // Same register for both reads and the write: both reads return the pre-write value.
    step(1'b1, 4'd6, 4'd6, 4'd6, 1'b1, ADD, 32'd0);
    expect_at(0, SelAlu, 32'h0001_0FB2, "rmw_alu");
    probe(4'd6, 32'h0001_0FB2, "rmw_r6");

    // r0 is an ordinary register.
    step(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, PASSB, 32'h0000_0055);
    probe(4'd0, 32'h0000_0055, "write_r0");

    // Reset during a write discards everything.
    step(1'b1, 4'd0, 4'd0, 4'd1, 1'b0, PASSB, 32'h0000_1234);
    step(1'b1, 4'd1, 4'd0, 4'd1, 1'b0, ADD, 32'd1);
    rst = 1'b1;
    expect_at(0, SelLfsr, 32'h0000_1234, "pre_reset_lfsr");
    expect_at(1, SelLfsr, 32'd0, "post_reset_lfsr");
    expect_at(1, SelRes, 32'd0, "post_reset_result_q");
`ifdef LFSR_DP_DBG_EN
    expect_at(1, SelWrCnt, 32'd0, "post_reset_wr_count");
`endif
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, PASSB, 32'd0);
    rst = 1'b0;
    probe(4'd6, 32'd0, "post_reset_r6");
    probe(4'd0, 32'd0, "post_reset_r0");

    repeat (3) @(posedge clk);
    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s: never sampled, expected 0x%08h", sb[0].name, sb[0].exp);
      sb.delete(0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass == n_checks) begin
      $display("PASS");
    end else begin
      $display("FAIL: %0d check(s) failed", n_checks - n_pass);
    end
    $finish;
  end
endmodule
